// File: rtl/sp_pkg.sv
// Shared ISA encodings, decoded-operation enum and the decoded bundle handed to EX.
package sp_pkg;

  localparam int SP_XLEN  = 32;
  localparam int SP_REG_W = 5;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_ANDI  = 6'd1;
  localparam logic [5:0] OPC_ORI   = 6'd2;
  localparam logic [5:0] OPC_ADDI  = 6'd3;
  localparam logic [5:0] OPC_SUBI  = 6'd4;
  localparam logic [5:0] OPC_LW    = 6'd5;
  localparam logic [5:0] OPC_SW    = 6'd6;
  localparam logic [5:0] OPC_BEQ   = 6'd7;
  localparam logic [5:0] OPC_BNE   = 6'd8;
  localparam logic [5:0] OPC_LUI   = 6'd9;
  localparam logic [5:0] OPC_J     = 6'd10;
  localparam logic [5:0] OPC_JAL   = 6'd11;

  localparam logic [5:0] FN_AND = 6'd0;
  localparam logic [5:0] FN_OR  = 6'd1;
  localparam logic [5:0] FN_ADD = 6'd2;
  localparam logic [5:0] FN_SUB = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;
  localparam logic [5:0] FN_SLL = 6'd5;
  localparam logic [5:0] FN_NOR = 6'd6;
  localparam logic [5:0] FN_JR  = 6'd7;

  typedef enum logic [4:0] {
    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_NOR, OP_JR,
    OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
    OP_LUI, OP_J, OP_JAL, OP_NOP
  } id_op_e;

  typedef struct packed {
    id_op_e                op;
    logic [SP_REG_W-1:0]   rs;
    logic [SP_REG_W-1:0]   rt;
    logic [SP_XLEN-1:0]    rs_val;
    logic [SP_XLEN-1:0]    rt_val;
    logic [SP_XLEN-1:0]    imm;
    logic [SP_REG_W-1:0]   shamt;
    logic                  wr_en;
    logic [SP_REG_W-1:0]   wr_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [SP_XLEN-1:0]    link;
  } dec_bundle_t;

endpackage

// File: rtl/sp_regfile.sv
// Architectural register file: one write port, two combinational read ports
// (the rs/rt ports also feed jr and branch resolution). r0 is writable.
module sp_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_a_addr,
  output logic [XLEN-1:0]  rd_a_data,
  input  logic [IDX_W-1:0] rd_b_addr,
  output logic [XLEN-1:0]  rd_b_data
);

  logic [XLEN-1:0] r [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else if (wr_en) begin
      r[wr_addr] <= wr_data;
    end
  end

  // Reads return pre-write contents; same-cycle write-back is resolved downstream.
  assign rd_a_data = r[rd_a_addr];
  assign rd_b_data = r[rd_b_addr];

endmodule

// File: rtl/sp_fetch_decode.sv
// Front stage of the SP core: owns the PC and register file, decodes one
// instruction per accepted cycle and resolves branches/jumps combinationally.
module sp_fetch_decode
  import sp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_addr,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             id_valid,
  output logic [4:0]       id_op,
  output logic [IDX_W-1:0] id_rs,
  output logic [IDX_W-1:0] id_rt,
  output logic [XLEN-1:0]  id_rs_val,
  output logic [XLEN-1:0]  id_rt_val,
  output logic [XLEN-1:0]  id_imm,
  output logic [4:0]       id_shamt,
  output logic             id_wr_en,
  output logic [IDX_W-1:0] id_wr_addr,
  output logic             id_mem_rd,
  output logic             id_mem_wr,
  output logic [XLEN-1:0]  id_link
);

  function automatic logic signed [XLEN-1:0] sext16(input logic signed [15:0] v);
    return XLEN'(v);
  endfunction

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_plus4_p0;
  logic [XLEN-1:0] pc_next_p0;
  logic [XLEN-1:0] rs_val_p0;
  logic [XLEN-1:0] rt_val_p0;
  logic signed [XLEN-1:0] imm_sx_p0;
  logic [5:0]      opc_p0;
  logic [5:0]      fn_p0;
  dec_bundle_t     dec_p0;
  dec_bundle_t     bundle_p1;
  logic            vld_p1;

  sp_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_a_addr (inst[25:21]),
    .rd_a_data (rs_val_p0),
    .rd_b_addr (inst[20:16]),
    .rd_b_data (rt_val_p0)
  );

  // ---- stage p0: decode and next-PC resolution ----
  assign opc_p0      = inst[31:26];
  assign fn_p0       = inst[5:0];
  assign pc_plus4_p0 = pc_p0 + XLEN'(4);
  assign imm_sx_p0   = sext16(inst[15:0]);

  always_comb begin
    dec_p0         = '0;
    dec_p0.op      = OP_NOP;
    dec_p0.rs      = inst[25:21];
    dec_p0.rt      = inst[20:16];
    dec_p0.rs_val  = rs_val_p0;
    dec_p0.rt_val  = rt_val_p0;
    dec_p0.imm     = imm_sx_p0;
    dec_p0.shamt   = inst[10:6];
    dec_p0.wr_en   = 1'b1;
    dec_p0.wr_addr = inst[20:16];
    dec_p0.link    = pc_plus4_p0;
    pc_next_p0     = pc_plus4_p0;
    case (opc_p0)
      OPC_RTYPE: begin
        dec_p0.wr_addr = inst[15:11];
        case (fn_p0)
          FN_AND:  dec_p0.op = OP_AND;
          FN_OR:   dec_p0.op = OP_OR;
          FN_ADD:  dec_p0.op = OP_ADD;
          FN_SUB:  dec_p0.op = OP_SUB;
          FN_SLT:  dec_p0.op = OP_SLT;
          FN_SLL:  dec_p0.op = OP_SLL;
          FN_NOR:  dec_p0.op = OP_NOR;
          FN_JR: begin
            dec_p0.op    = OP_JR;
            dec_p0.wr_en = 1'b0;
            pc_next_p0   = rs_val_p0;
          end
          default: begin
            dec_p0.op    = OP_NOP;
            dec_p0.wr_en = 1'b0;
          end
        endcase
      end
      OPC_ANDI: begin
        dec_p0.op  = OP_ANDI;
        dec_p0.imm = {16'h0, inst[15:0]};
      end
      OPC_ORI: begin
        dec_p0.op  = OP_ORI;
        dec_p0.imm = {16'h0, inst[15:0]};
      end
      OPC_ADDI: dec_p0.op = OP_ADDI;
      OPC_SUBI: dec_p0.op = OP_SUBI;
      OPC_LW: begin
        dec_p0.op     = OP_LW;
        dec_p0.mem_rd = 1'b1;
      end
      OPC_SW: begin
        dec_p0.op     = OP_SW;
        dec_p0.wr_en  = 1'b0;
        dec_p0.mem_wr = 1'b1;
      end
      OPC_BEQ: begin
        dec_p0.op    = OP_BEQ;
        dec_p0.wr_en = 1'b0;
        if (rs_val_p0 == rt_val_p0) pc_next_p0 = pc_plus4_p0 + (imm_sx_p0 <<< 2);
      end
      OPC_BNE: begin
        dec_p0.op    = OP_BNE;
        dec_p0.wr_en = 1'b0;
        if (rs_val_p0 != rt_val_p0) pc_next_p0 = pc_plus4_p0 + (imm_sx_p0 <<< 2);
      end
      OPC_LUI: begin
        dec_p0.op  = OP_LUI;
        dec_p0.imm = {inst[15:0], 16'h0};
      end
      default: begin
        // Every opcode from 10 upward is a jump; only 11 links.
        dec_p0.op      = (opc_p0 == OPC_JAL) ? OP_JAL : OP_J;
        dec_p0.wr_en   = (opc_p0 == OPC_JAL);
        dec_p0.wr_addr = 5'd31;
        pc_next_p0     = {pc_p0[31:28], inst[25:0], 2'b00};
      end
    endcase
  end

  // ---- stage p1: registered PC and decoded bundle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0     <= '0;
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        pc_p0     <= pc_next_p0;
        bundle_p1 <= dec_p0;
      end
    end
  end

  assign inst_addr  = pc_p0;
  assign id_valid   = vld_p1;
  assign id_op      = bundle_p1.op;
  assign id_rs      = bundle_p1.rs;
  assign id_rt      = bundle_p1.rt;
  assign id_rs_val  = bundle_p1.rs_val;
  assign id_rt_val  = bundle_p1.rt_val;
  assign id_imm     = bundle_p1.imm;
  assign id_shamt   = bundle_p1.shamt;
  assign id_wr_en   = bundle_p1.wr_en;
  assign id_wr_addr = bundle_p1.wr_addr;
  assign id_mem_rd  = bundle_p1.mem_rd;
  assign id_mem_wr  = bundle_p1.mem_wr;
  assign id_link    = bundle_p1.link;

endmodule

// File: tb/tb_sp_fetch_decode.sv
// Randomized bench for sp_fetch_decode against an ISA-level reference model
// (register array + PC), plus the directed scenarios for reset, branches and jumps.
module tb_sp_fetch_decode;
  import sp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] inst_addr;
  logic        id_valid;
  logic [4:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_shamt;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_mem_rd, id_mem_wr;
  logic [31:0] id_link;

  sp_fetch_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .id_valid   (id_valid),
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_val  (id_rs_val),
    .id_rt_val  (id_rt_val),
    .id_imm     (id_imm),
    .id_shamt   (id_shamt),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_mem_rd  (id_mem_rd),
    .id_mem_wr  (id_mem_wr),
    .id_link    (id_link)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  id_op_e      r_ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_NOR, OP_JR};
  id_op_e      i_ops [9] = '{OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI};

  id_op_e      e_op;
  logic        e_wr_en, e_mem_rd, e_mem_wr, e_imm_chk, e_sh_chk;
  logic [4:0]  e_wr_addr;
  logic [31:0] e_imm, e_npc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic predict(input logic [31:0] ins);
    int          opc = int'(ins[31:26]);
    int          fn  = int'(ins[5:0]);
    logic [31:0] a   = m_r[ins[25:21]];
    logic [31:0] b   = m_r[ins[20:16]];
    logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
    e_npc     = m_pc + 32'd4;
    e_mem_rd  = 1'b0;
    e_mem_wr  = 1'b0;
    e_imm     = sx;
    e_imm_chk = (opc >= 1 && opc <= 9);
    e_sh_chk  = (opc == 0);
    if (opc == 0) begin
      e_wr_addr = ins[15:11];
      e_op      = (fn < 8) ? r_ops[fn] : OP_NOP;
      e_wr_en   = (fn < 7);
      if (fn == 7) e_npc = a;
    end else if (opc >= 10) begin
      e_op      = (opc == 11) ? OP_JAL : OP_J;
      e_wr_en   = (opc == 11);
      e_wr_addr = 5'd31;
      e_npc     = {m_pc[31:28], ins[25:0], 2'b00};
    end else begin
      e_op      = i_ops[opc-1];
      e_wr_addr = ins[20:16];
      e_wr_en   = !(opc == 6 || opc == 7 || opc == 8);
      e_mem_rd  = (opc == 5);
      e_mem_wr  = (opc == 6);
      if (opc == 1 || opc == 2) e_imm = {16'h0, ins[15:0]};
      if (opc == 9) e_imm = {ins[15:0], 16'h0};
      if ((opc == 7 && a == b) || (opc == 8 && a != b)) e_npc = m_pc + 32'd4 + (sx * 32'd4);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] a, b, link;
    in_valid = v; inst = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    a = m_r[ins[25:21]];
    b = m_r[ins[20:16]];
    link = m_pc + 32'd4;
    if (v) predict(ins);
    @(posedge clk); #1;
    if (we) m_r[wa] = wd;
    if (v) m_pc = e_npc;
    check("inst_addr", inst_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(v));
    if (v) begin
      check("id_op", 32'(id_op), 32'(e_op));
      check("id_rs", 32'(id_rs), 32'(ins[25:21]));
      check("id_rt", 32'(id_rt), 32'(ins[20:16]));
      check("id_rs_val", id_rs_val, a);
      check("id_rt_val", id_rt_val, b);
      if (e_imm_chk) check("id_imm", id_imm, e_imm);
      if (e_sh_chk) check("id_shamt", 32'(id_shamt), 32'(ins[10:6]));
      check("id_wr_en", 32'(id_wr_en), 32'(e_wr_en));
      if (e_wr_en) check("id_wr_addr", 32'(id_wr_addr), 32'(e_wr_addr));
      check("id_mem_rd", 32'(id_mem_rd), 32'(e_mem_rd));
      check("id_mem_wr", 32'(id_mem_wr), 32'(e_mem_wr));
      check("id_link", id_link, link);
    end
    in_valid = 1'b0;
    wb_en = 1'b0;
  endtask

  task automatic idle_wb(input logic [4:0] wa, input logic [31:0] wd);
    cycle(1'b0, 32'h0, 1'b1, wa, wd);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc = '0;
  endtask

  initial begin
    logic [31:0] rnd, wd, acc;
    logic [5:0]  opc;
    logic        v, we;
    logic [4:0]  wa;

    model_reset();
    #12;
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addi r2,r1,-3 at PC 0 with r1=5
    idle_wb(5'd1, 32'd5);
    cycle(1'b1, 32'h0C22FFFD, 1'b0, 5'd0, 32'h0);
    check("tp_addi_op", 32'(id_op), 32'(OP_ADDI));
    check("tp_addi_imm", id_imm, 32'hFFFFFFFD);
    check("tp_addi_rs_val", id_rs_val, 32'd5);
    check("tp_addi_wr_addr", 32'(id_wr_addr), 32'd2);
    check("tp_addi_pc", inst_addr, 32'h4);

    // beq r3,r4,-2 at PC 0x20: taken then not taken
    idle_wb(5'd3, 32'd7);
    idle_wb(5'd4, 32'd7);
    cycle(1'b1, {6'd10, 26'h8}, 1'b0, 5'd0, 32'h0);
    check("tp_j20", inst_addr, 32'h20);
    cycle(1'b1, {6'd7, 5'd3, 5'd4, 16'hFFFE}, 1'b0, 5'd0, 32'h0);
    check("tp_beq_taken", inst_addr, 32'h1C);
    cycle(1'b1, {6'd10, 26'h8}, 1'b0, 5'd0, 32'h0);
    idle_wb(5'd4, 32'd8);
    cycle(1'b1, {6'd7, 5'd3, 5'd4, 16'hFFFE}, 1'b0, 5'd0, 32'h0);
    check("tp_beq_not_taken", inst_addr, 32'h24);

    // jal 0x100 at PC 0x10, then jr r5
    cycle(1'b1, {6'd10, 26'h4}, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, {6'd11, 26'h100}, 1'b0, 5'd0, 32'h0);
    check("tp_jal_pc", inst_addr, 32'h400);
    check("tp_jal_wr_addr", 32'(id_wr_addr), 32'd31);
    check("tp_jal_link", id_link, 32'h14);
    idle_wb(5'd5, 32'h80);
    cycle(1'b1, {6'd0, 5'd5, 5'd0, 5'd0, 5'd0, 6'd7}, 1'b0, 5'd0, 32'h0);
    check("tp_jr_pc", inst_addr, 32'h80);

    // immediates and idle hold
    cycle(1'b1, {6'd1, 5'd1, 5'd7, 16'hFFFF}, 1'b0, 5'd0, 32'h0);
    check("tp_andi_imm", id_imm, 32'h0000FFFF);
    cycle(1'b1, {6'd9, 5'd0, 5'd8, 16'h1234}, 1'b0, 5'd0, 32'h0);
    check("tp_lui_imm", id_imm, 32'h12340000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    check("tp_idle_pc", inst_addr, 32'h88);

    // randomized instruction/write-back traffic
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      opc = 6'($urandom_range(0, 13));
      if (opc == 6'd0) rnd[5:0] = 6'($urandom_range(0, 9));
      if ((opc == 6'd7 || opc == 6'd8) && $urandom_range(0, 1) == 1) rnd[20:16] = rnd[25:21];
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(0, 31));
      wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
      cycle(v, {opc, rnd[25:0]}, we, wa, wd);
    end

    // steer to PC 0x40, then pulse reset mid-run
    idle_wb(5'd9, 32'h40);
    cycle(1'b1, {6'd0, 5'd9, 5'd0, 5'd0, 5'd0, 6'd7}, 1'b0, 5'd0, 32'h0);
    check("tp_pc40", inst_addr, 32'h40);
    idle_wb(5'd10, 32'hDEADBEEF);
    cycle(1'b1, {6'd3, 5'd10, 5'd11, 16'h0001}, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_inst_addr", inst_addr, 32'h0);
    check("mid_rst_id_valid", 32'(id_valid), 32'h0);
    check("mid_rst_id_rs_val", id_rs_val, 32'h0);
    check("mid_rst_id_wr_en", 32'(id_wr_en), 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.u_rf.r[i];
    check("mid_rst_regs", acc, 32'h0);
    @(posedge clk); #1;
    check("mid_rst_hold_valid", 32'(id_valid), 32'h0);
    check("mid_rst_hold_pc", inst_addr, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // bne r6,r0 with same-cycle write-back of r6 sees the old value
    cycle(1'b1, {6'd8, 5'd6, 5'd0, 16'h0005}, 1'b1, 5'd6, 32'd9);
    check("tp_bne_old_rs_val", id_rs_val, 32'h0);
    check("tp_bne_not_taken", inst_addr, 32'h4);
    cycle(1'b1, {6'd0, 5'd6, 5'd0, 5'd12, 5'd0, 6'd2}, 1'b0, 5'd0, 32'h0);
    check("tp_r6_written", id_rs_val, 32'd9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
